inst_fetch: RTL and testbench

- PC-generation and fetch stage sitting directly upstream of the combinational instruction ROM.
- Drives the ROM word address from its PC register and captures the returned word together with its PC into an IF/ID output register.
- Hands the captured instruction to decode over a valid/ready handshake.
- Handles back-pressure, redirects (branch/jump/trap targets), misaligned targets and a program-halt request.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/ifid_reg.sv | 40 ++++
 rtl/inst_fetch.sv | 91 +++++++++
 tb/tb_inst_fetch.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013; // addi x0,x0,0

  // Fetch sequencer states
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Payload carried by the IF/ID register
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            misalign;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID output register with a valid/ready handshake.
// Priority: flush > load > fire > hold.
module ifid_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INST_P = NOP_INST
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  flush,
  input  logic  ready,
  input  ifid_t din,
  output logic  valid,
  output ifid_t dout
);

  // The payload register. It keeps its pc after a fire or a flush.
  // Only the instruction word is returned to NOP in those cases.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid         <= 1'b0;
      dout.pc       <= '0;
      dout.inst     <= NOP_INST_P;
      dout.misalign <= 1'b0;
    end else if (flush) begin
      valid         <= 1'b0;
      dout.inst     <= NOP_INST_P;
      dout.misalign <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid         <= 1'b0;
      dout.inst     <= NOP_INST_P;
      dout.misalign <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// PC generation and fetch stage in front of a combinational instruction ROM.
module inst_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_AW    = 14,
  parameter logic [31:0] NOP_INST_P = NOP_INST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [31:0]        out_inst,
  output logic               out_misalign,
  output logic               halted
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            stuck_q, stuck_d; // parked on a misaligned pc until redirect
  logic            misaligned, adv;
  ifid_t           ifid_in, ifid_out;

  assign imem_addr  = pc_q[IMEM_AW+1:2];
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign adv        = (state_q == RUN) && !halt_req && !redirect_valid &&
                      !stuck_q && (!out_valid || out_ready);

  // A misaligned pc is reported as a NOP tagged misalign and is not fetched.
  always_comb begin
    ifid_in.pc       = pc_q;
    ifid_in.inst     = misaligned ? NOP_INST_P : imem_data;
    ifid_in.misalign = misaligned;
  end

  // Next pc, the stuck flag and the next FSM state. A redirect wins over everything.
  always_comb begin
    pc_d    = pc_q;
    stuck_d = stuck_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      stuck_d = 1'b0;
    end else if (adv) begin
      if (misaligned) stuck_d = 1'b1;
      else            pc_d    = pc_q + 32'd4;
    end
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_req) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // PC, the stuck flag and the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      stuck_q <= 1'b0;
      state_q <= BOOT;
    end else begin
      pc_q    <= pc_d;
      stuck_q <= stuck_d;
      state_q <= state_d;
    end
  end

  ifid_reg #(.NOP_INST_P(NOP_INST_P)) u_ifid (
    .clk   (clk),
    .rst   (rst),
    .load  (adv),
    .flush (redirect_valid),
    .ready (out_ready),
    .din   (ifid_in),
    .valid (out_valid),
    .dout  (ifid_out)
  );

  assign out_pc       = ifid_out.pc;
  assign out_inst     = ifid_out.inst;
  assign out_misalign = ifid_out.misalign;
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a directed vector table, then random stimulus against a behavioural model.
module tb_inst_fetch;

  localparam int          AW  = 14;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, redirect_valid, halt_req, out_ready;
  logic [31:0]   redirect_pc, imem_data, out_pc, out_inst;
  logic [AW-1:0] imem_addr;
  logic          out_valid, out_misalign, halted;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  // ROM: word k holds 0x1000+k
  assign imem_data = 32'h1000 + 32'(imem_addr);

  inst_fetch #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_misalign(out_misalign), .halted(halted)
  );

  // Behavioural model
  bit          m_init = 0, m_booting, m_halted, m_stuck, m_valid, m_mis;
  logic [31:0] m_pc, m_opc, m_inst;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000 + ((a >> 2) & 32'h3FFF);
  endfunction

  task automatic model_step(input bit r, input bit rv, input logic [31:0] rpc,
                            input bit hr, input bit rdy);
    bit running, can_load;
    if (r) begin
      m_init = 1; m_pc = 0; m_booting = 1; m_halted = 0; m_stuck = 0;
      m_valid = 0; m_opc = 0; m_inst = NOP; m_mis = 0;
      return;
    end
    if (!m_init) return;
    running  = !m_booting && !m_halted;
    can_load = running && !hr && !rv && !m_stuck && (!m_valid || rdy);
    if (rv) begin
      m_pc = rpc; m_valid = 0; m_inst = NOP; m_mis = 0; m_stuck = 0;
    end else if (can_load) begin
      m_opc = m_pc; m_valid = 1;
      if (m_pc % 4 != 0) begin m_inst = NOP; m_mis = 1; m_stuck = 1; end
      else begin m_inst = rom(m_pc); m_mis = 0; m_pc = m_pc + 32'd4; end
    end else if (m_valid && rdy) begin
      m_valid = 0; m_inst = NOP; m_mis = 0;
    end
    if (m_booting) m_booting = 0;
    else if (running && hr) m_halted = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_model();
    if (!m_init) return;
    chk("m_valid", 32'(out_valid), 32'(m_valid));
    chk("m_pc",    out_pc,         m_opc);
    chk("m_inst",  out_inst,       m_inst);
    chk("m_mis",   32'(out_misalign), 32'(m_mis));
    chk("m_halt",  32'(halted),    32'(m_halted));
    chk("m_addr",  32'(imem_addr), (m_pc >> 2) & 32'h3FFF);
  endtask

  // Directed vectors: inputs for a cycle plus outputs expected during that cycle
  typedef struct {
    bit rst, rv; logic [31:0] rpc; bit hr, rdy;
    bit chk; bit ev; logic [31:0] epc, einst; bit emis, ehalt; logic [31:0] eaddr;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(bit r, bit rv, logic [31:0] rpc, bit hr, bit rdy, bit c,
                              bit ev, logic [31:0] epc, logic [31:0] ei, bit em, bit eh,
                              logic [31:0] ea);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.hr = hr; v.rdy = rdy; v.chk = c;
    v.ev = ev; v.epc = epc; v.einst = ei; v.emis = em; v.ehalt = eh; v.eaddr = ea;
    return v;
  endfunction

  task automatic cycle(input bit r, input bit rv, input logic [31:0] rpc,
                       input bit hr, input bit rdy);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; halt_req = hr; out_ready = rdy;
    #1;
    chk_model();
  endtask

  initial begin
    rst = 1; redirect_valid = 0; redirect_pc = 0; halt_req = 0; out_ready = 1;
    //           rst rv rpc            hr rdy chk  v  pc            inst          mis hlt addr
    vt.push_back(mk(1, 0, 0,            0, 1, 0,  0, 0,            NOP,          0, 0, 0));
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  0, 0,            NOP,          0, 0, 0));     // BOOT
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  0, 0,            NOP,          0, 0, 0));
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  1, 0,            32'h1000,     0, 0, 1));
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  1, 4,            32'h1001,     0, 0, 2));
    vt.push_back(mk(0, 0, 0,            0, 0, 1,  1, 8,            32'h1002,     0, 0, 3));     // stall x3
    vt.push_back(mk(0, 0, 0,            0, 0, 1,  1, 8,            32'h1002,     0, 0, 3));
    vt.push_back(mk(0, 0, 0,            0, 0, 1,  1, 8,            32'h1002,     0, 0, 3));
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  1, 8,            32'h1002,     0, 0, 3));
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  1, 12,           32'h1003,     0, 0, 4));
    vt.push_back(mk(0, 1, 32'h40,       0, 1, 1,  1, 16,           32'h1004,     0, 0, 5));     // redirect
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  0, 16,           NOP,          0, 0, 32'h10));
    vt.push_back(mk(0, 1, 32'h42,       0, 0, 1,  1, 32'h40,       32'h1010,     0, 0, 32'h11)); // stalled redirect
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  0, 32'h40,       NOP,          0, 0, 32'h10));
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  1, 32'h42,       NOP,          1, 0, 32'h10)); // misaligned
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  0, 32'h42,       NOP,          0, 0, 32'h10));
    vt.push_back(mk(0, 1, 32'h80,       0, 1, 1,  0, 32'h42,       NOP,          0, 0, 32'h10));
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  0, 32'h42,       NOP,          0, 0, 32'h20));
    vt.push_back(mk(0, 0, 0,            1, 0, 1,  1, 32'h80,       32'h1020,     0, 0, 32'h21)); // halt req
    vt.push_back(mk(0, 0, 0,            1, 0, 1,  1, 32'h80,       32'h1020,     0, 1, 32'h21));
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  1, 32'h80,       32'h1020,     0, 1, 32'h21));
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  0, 32'h80,       NOP,          0, 1, 32'h21));
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  0, 32'h80,       NOP,          0, 1, 32'h21));
    vt.push_back(mk(1, 0, 0,            0, 1, 1,  0, 32'h80,       NOP,          0, 1, 32'h21));
    vt.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 1, 1, 0, 0,            NOP,          0, 0, 0));     // BOOT redirect
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  0, 0,            NOP,          0, 0, 32'h3FFF));
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  1, 32'hFFFF_FFFC, 32'h4FFF,    0, 0, 0));     // wrap
    vt.push_back(mk(0, 0, 0,            0, 1, 1,  1, 0,            32'h1000,     0, 0, 1));

    foreach (vt[i]) begin
      cycle(vt[i].rst, vt[i].rv, vt[i].rpc, vt[i].hr, vt[i].rdy);
      if (vt[i].chk) begin
        chk($sformatf("v%0d_valid", i), 32'(out_valid),    32'(vt[i].ev));
        chk($sformatf("v%0d_pc", i),    out_pc,            vt[i].epc);
        chk($sformatf("v%0d_inst", i),  out_inst,          vt[i].einst);
        chk($sformatf("v%0d_mis", i),   32'(out_misalign), 32'(vt[i].emis));
        chk($sformatf("v%0d_halt", i),  32'(halted),       32'(vt[i].ehalt));
        chk($sformatf("v%0d_addr", i),  32'(imem_addr),    vt[i].eaddr);
      end
      @(posedge clk);
      model_step(vt[i].rst, vt[i].rv, vt[i].rpc, vt[i].hr, vt[i].rdy);
    end

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      bit r, rv, hr, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 59) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      hr  = ($urandom_range(0, 49) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 5))
        0:       rpc = 32'hFFFF_FFF0 + {28'h0, $urandom_range(0, 15)};
        1:       rpc = $urandom;
        default: rpc = {$urandom_range(0, 32'hFFFF), 2'b00};
      endcase
      cycle(r, rv, rpc, hr, rdy);
      @(posedge clk);
      model_step(r, rv, rpc, hr, rdy);
    end

    @(negedge clk); #1;
    chk_model();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
